// File: rtl/systolic_array_if.sv
// Operand stream and result byte stream for the 2x2 systolic matrix-multiply unit.
// The master drives operands and out_ready. The slave (the array) returns bytes and status.
interface systolic_array_if;
  logic       clear;
  logic       en;
  logic [7:0] a_data0;
  logic [7:0] a_data1;
  logic [7:0] b_data0;
  logic [7:0] b_data1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  modport master (
    output clear, en, a_data0, a_data1, b_data0, b_data1, out_ready,
    input  out_data, out_valid, busy, done
  );

  modport slave (
    input  clear, en, a_data0, a_data1, b_data0, b_data1, out_ready,
    output out_data, out_valid, busy, done
  );
endinterface

// File: rtl/systolic_array.sv
// 2x2 output-stationary systolic multiplier with 16-bit saturating accumulators.
// Results are drained as eight bytes over a valid/ready handshake.
module systolic_array (
  input  logic            clk,
  input  logic            rst_n,
  systolic_array_if.slave io
);
  typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, DRAIN = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic [2:0]  idx;
  logic        done_q;
  logic [15:0] acc     [4];  // PE order: 00, 01, 10, 11
  logic [15:0] acc_nxt [4];
  logic [7:0]  pe_a    [4];
  logic [7:0]  pe_b    [4];
  // Only the forward registers that feed a neighbour are kept.
  logic [7:0]  a_fwd00, b_fwd00, a_fwd10, b_fwd01;
  logic        advance, accept, last;

  assign advance = io.en && (state != DRAIN);
  assign accept  = (state == DRAIN) && io.out_ready;
  assign last    = accept && (idx == 3'd7);

  always_comb begin
    pe_a[0] = io.a_data0;  pe_b[0] = io.b_data0;
    pe_a[1] = a_fwd00;     pe_b[1] = io.b_data1;
    pe_a[2] = io.a_data1;  pe_b[2] = b_fwd00;
    pe_a[3] = a_fwd10;     pe_b[3] = b_fwd01;
  end

  always_comb begin : mac
    logic [16:0] sum;
    for (int i = 0; i < 4; i++) begin
      sum        = {1'b0, acc[i]} + {1'b0, 16'(pe_a[i]) * 16'(pe_b[i])};
      acc_nxt[i] = sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

  // NOTE: every signal written in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.en) state_nxt = COMPUTE;
      COMPUTE: if (io.en && cnt == 2'd3) state_nxt = DRAIN;
      DRAIN:   if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (io.clear) state_nxt = IDLE;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the accumulators are a small flop array rather than a RAM, so they are reset and cleared like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      a_fwd00 <= '0;
      b_fwd00 <= '0;
      a_fwd10 <= '0;
      b_fwd01 <= '0;
      cnt     <= '0;
      idx     <= '0;
      done_q  <= 1'b0;
    end else if (io.clear || last) begin
      // Completion and clear both return the array to a clean IDLE. Only completion pulses done.
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      a_fwd00 <= '0;
      b_fwd00 <= '0;
      a_fwd10 <= '0;
      b_fwd01 <= '0;
      cnt     <= '0;
      idx     <= '0;
      done_q  <= !io.clear;
    end else begin
      done_q <= 1'b0;
      if (advance) begin
        acc     <= acc_nxt;
        a_fwd00 <= pe_a[0];
        b_fwd00 <= pe_b[0];
        a_fwd10 <= pe_a[2];
        b_fwd01 <= pe_b[1];
        cnt     <= (state == IDLE) ? 2'd1 : cnt + 2'd1;
        if (state == COMPUTE && cnt == 2'd3) idx <= '0;
      end
      if (accept) idx <= idx + 3'd1;
    end
  end

  assign io.out_valid = (state == DRAIN);
  assign io.busy      = (state != IDLE);
  assign io.done      = done_q;

  // The byte mux reads only registered state, so out_data holds while the consumer stalls.
  always_comb begin
    logic [15:0] sel;
    sel         = acc[idx[2:1]];
    io.out_data = '0;
    if (state == DRAIN) io.out_data = idx[0] ? sel[15:8] : sel[7:0];
  end
endmodule

// File: tb/tb_systolic_array.sv
// Scoreboard bench for systolic_array: a matrix model pushes the expected bytes.
// The drain loop pops and compares them as the DUT hands them over.
module tb_systolic_array;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  systolic_array_if io ();
  systolic_array dut (.clk(clk), .rst_n(rst_n), .io(io));

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];

  localparam logic [31:0] CASE1_A = 32'h01020304;
  localparam logic [31:0] CASE1_B = 32'h05060708;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops(input logic e, input logic [7:0] a0, a1, b0, b1);
    io.en      = e;
    io.a_data0 = a0;
    io.a_data1 = a1;
    io.b_data0 = b0;
    io.b_data1 = b1;
  endtask

  // Reference C = A x B. A = {in0,in1,in2,in3}, B = {w0,w1,w2,w3}, both row-major.
  task automatic model(input logic [31:0] am, input logic [31:0] bm);
    int c [4];
    int in0, in1, in2, in3, w0, w1, w2, w3;
    in0 = int'(am[31:24]); in1 = int'(am[23:16]); in2 = int'(am[15:8]); in3 = int'(am[7:0]);
    w0  = int'(bm[31:24]); w1  = int'(bm[23:16]); w2  = int'(bm[15:8]); w3  = int'(bm[7:0]);
    c[0] = in0 * w0 + in1 * w2;
    c[1] = in0 * w1 + in1 * w3;
    c[2] = in2 * w0 + in3 * w2;
    c[3] = in2 * w1 + in3 * w3;
    for (int i = 0; i < 4; i++) begin
      if (c[i] > 65535) c[i] = 65535;
      exp_q.push_back(8'(c[i]));
      exp_q.push_back(8'(c[i] >> 8));
    end
  endtask

  // Skewed feeder pattern with an optional en=0 stall after pattern cycle 1.
  task automatic feed(input logic [31:0] am, input logic [31:0] bm, input int stall);
    model(am, bm);
    drive_ops(1'b1, am[31:24], 8'h00, bm[31:24], 8'h00);
    step();
    drive_ops(1'b1, am[23:16], am[15:8], bm[15:8], bm[23:16]);
    step();
    for (int k = 0; k < stall; k++) begin
      io.en = 1'b0;
      @(negedge clk);
      total++;
      if (io.busy !== 1'b1) begin
        bad++;
        $display("FAIL stall_busy k=%0d got=%b want=1", k, io.busy);
      end
      step();
    end
    drive_ops(1'b1, 8'h00, am[7:0], 8'h00, bm[7:0]);
    step();
    @(negedge clk);
    total++;
    if (io.out_valid !== 1'b0 || io.busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_drain valid=%b busy=%b want valid=0 busy=1", io.out_valid, io.busy);
    end
    drive_ops(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    io.en = 1'b0;
  endtask

  // Accepts up to 'limit' bytes. Mode 1 drives out_ready in a 1,0,0 repeating pattern.
  task automatic drain(input int mode, input int limit);
    int         got = 0;
    int         cyc = 0;
    bit         holding = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] e;
    while (got < limit && cyc < 100) begin
      io.out_ready = (mode == 0) || (cyc % 3 == 0);
      @(negedge clk);
      total++;
      if (io.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL drain_valid cyc=%0d got=%b want=1", cyc, io.out_valid);
      end
      if (holding) begin
        total++;
        if (io.out_data !== held) begin
          bad++;
          $display("FAIL hold_data cyc=%0d got=%h want=%h", cyc, io.out_data, held);
        end
      end
      if (io.out_valid === 1'b1 && io.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_byte got=%h want=none", io.out_data);
        end else begin
          e = exp_q.pop_front();
          if (io.out_data !== e) begin
            bad++;
            $display("FAIL byte idx=%0d got=%h want=%h", got, io.out_data, e);
          end
        end
        got++;
        holding = 1'b0;
      end else if (io.out_valid === 1'b1) begin
        holding = 1'b1;
        held    = io.out_data;
      end
      step();
      cyc++;
    end
    io.out_ready = 1'b0;
    if (got < limit) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got=%0d want=%0d", got, limit);
    end
    if (limit == 8) begin
      @(negedge clk);
      total++;
      if (io.done !== 1'b1 || io.out_valid !== 1'b0 || io.busy !== 1'b0) begin
        bad++;
        $display("FAIL done_cycle done=%b valid=%b busy=%b want 1 0 0", io.done, io.out_valid, io.busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    io.clear     = 1'b0;
    io.out_ready = 1'b0;
    drive_ops(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) step();
    total++;
    if (io.out_data !== 8'h00 || io.out_valid !== 1'b0 || io.busy !== 1'b0 || io.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs data=%h valid=%b busy=%b done=%b want all 0",
               io.out_data, io.out_valid, io.busy, io.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    feed(CASE1_A, CASE1_B, 0);
    drain(0, 8);
    step();
    @(negedge clk);
    total++;
    if (io.done !== 1'b0) begin
      bad++;
      $display("FAIL done_width got=%b want=0", io.done);
    end
  endtask

  task automatic test_saturate();
    feed(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    drain(0, 8);
  endtask

  task automatic test_stall();
    feed(CASE1_A, CASE1_B, 3);
    drain(0, 8);
  endtask

  task automatic test_backpressure();
    feed(CASE1_A, CASE1_B, 0);
    drain(1, 8);
  endtask

  task automatic test_clear();
    feed(CASE1_A, CASE1_B, 0);
    drain(0, 3);
    io.clear = 1'b1;
    step();
    io.clear = 1'b0;
    @(negedge clk);
    total++;
    if (io.out_valid !== 1'b0 || io.busy !== 1'b0 || io.done !== 1'b0) begin
      bad++;
      $display("FAIL after_clear valid=%b busy=%b done=%b want 0 0 0", io.out_valid, io.busy, io.done);
    end
    exp_q.delete();
    step();
    feed(32'h01000001, 32'h09080706, 0);
    drain(0, 8);
  endtask

  task automatic test_reset_mid();
    step();
    drive_ops(1'b1, 8'd1, 8'd0, 8'd5, 8'd0);
    step();
    drive_ops(1'b1, 8'd2, 8'd3, 8'd7, 8'd6);
    step();
    rst_n = 1'b0;
    #2;
    total++;
    if (io.out_data !== 8'h00 || io.out_valid !== 1'b0 || io.busy !== 1'b0 || io.done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset data=%h valid=%b busy=%b done=%b want all 0",
               io.out_data, io.out_valid, io.busy, io.done);
    end
    drive_ops(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    feed(CASE1_A, CASE1_B, 0);
    drain(0, 8);
  endtask

  task automatic test_back_to_back();
    step();
    feed(CASE1_A, CASE1_B, 0);
    drain(0, 8);
    feed(32'h01000001, 32'h09080706, 0);
    drain(0, 8);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_stall();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_bytes got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule

// File: doc/systolic_array.md
# systolic_array

2x2 output-stationary systolic matrix-multiply unit that consumes the skewed operand stream from the data feeder (a_data0/1 row operands, b_data0/1 column operands) and computes C = A x B for 8-bit unsigned 2x2 matrices. Four MAC processing elements accumulate into 16-bit saturating registers. When the four compute cycles finish, a drain FSM streams the results out as bytes over a valid/ready handshake. The block sits directly downstream of the feeder and upstream of the output/IO stage.

## Interface
- No parameters; widths fixed: operands 8 b, accumulators 16 b.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous clear; zeroes accumulators and pipeline registers, forces IDLE.
- en  in  1  operand-valid/advance; low = stall (all compute state holds).
- a_data0  in  8  row-0 operand (enters PE00).
- a_data1  in  8  row-1 operand (enters PE10).
- b_data0  in  8  column-0 operand (enters PE00).
- b_data1  in  8  column-1 operand (enters PE01).
- out_data  out  8  result byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts byte when out_valid & out_ready.
- busy  out  1  high in COMPUTE or DRAIN.
- done  out  1  one-cycle pulse after the last byte is accepted.

## Operation
- PE(r,c) has an accumulator acc_rc (16 b), a forwarded-a register, and a forwarded-b register.
- Operand routing:
  - PE00 uses a_data0 and b_data0.
  - PE01 uses PE00.a_reg and b_data1.
  - PE10 uses a_data1 and PE00.b_reg.
  - PE11 uses PE10.a_reg and PE01.b_reg.
- On an advancing cycle (en=1, state IDLE or COMPUTE, clear=0):
  - acc <= sat16(acc + a*b), with an unsigned 8x8 -> 16-bit product.
  - Forward registers load the PE's current a and b.
- sat16: if the 17-bit sum exceeds 0xFFFF, the result is 0xFFFF.
- States: IDLE, COMPUTE, DRAIN. The counter cnt is 2 b, and byte index idx is 3 b.
  - IDLE: en=1 -> advance, cnt<=1, go to COMPUTE.
  - COMPUTE: en=1 -> advance, cnt<=cnt+1. If cnt==3, go to DRAIN with idx<=0. en=0 -> hold everything.
  - DRAIN: out_valid=1 and en is ignored. Each accepted byte does idx<=idx+1. Accept at idx==7 -> go to IDLE, pulse done, and zero the accumulators and forward registers.
- Drain byte order (idx 0..7): acc00[7:0], acc00[15:8], acc01 lo, acc01 hi, acc10 lo, acc10 hi, acc11 lo, acc11 hi.
- With A = [[in0,in1],[in2,in3]] and B = [[w0,w1],[w2,w3]], the expected feeder pattern is:
  - cycle 0: a0=in0, b0=w0.
  - cycle 1: a0=in1, a1=in2, b0=w2, b1=w1.
  - cycle 2: a1=in3, b1=w3.
  - cycle 3: all operands 0.
  - The accumulators then hold C exactly.
- clear has the highest priority over en and the handshake in any state. It zeroes acc, the forward registers, cnt, and idx; sets out_valid=0; and goes to IDLE. done is not pulsed.
- Zero operands still count as an advancing cycle.

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, done=0. All accumulators, forward registers, cnt, and idx are 0. State is IDLE.
- Accumulate latency: operands present on cycle t are reflected in acc at edge t+1.
- Compute takes 4 advancing cycles. out_valid rises in the cycle after the 4th advancing edge.
- out_data is registered/stable while out_valid=1 and out_ready=0. It must not change until it is accepted.
- Minimum drain is 8 cycles (out_ready held high).
- done is high for exactly 1 cycle, the cycle after the idx==7 acceptance. out_valid and busy are low in that same cycle.
- Back-to-back operation: en=1 in the done cycle starts a new computation (state is IDLE).
- Asynchronous reset mid-COMPUTE or mid-DRAIN returns immediately to the reset values.

## Test plan
- A=[[1,2],[3,4]], B=[[5,6],[7,8]] driven with the skewed pattern, out_ready=1 -> bytes 0x13,0x00,0x16,0x00,0x2B,0x00,0x32,0x00, then done for 1 cycle.
- All operands 0xFF -> each C = 130050, saturated; all 8 bytes are 0xFF.
- Same stimulus as case 1 with en=0 for 3 cycles between pattern cycles 1 and 2 (operands held) -> identical byte stream; busy=1 throughout the stall.
- Backpressure during drain: out_ready toggled 1,0,0,1,... -> out_data holds during the 0 cycles; the sequence is unchanged; done only after the 8th acceptance.
- clear asserted at idx==3 in DRAIN -> out_valid=0 next cycle, busy=0, no done pulse; a following computation with A=I, B=[[9,8],[7,6]] yields 0x09,0,0x08,0,0x07,0,0x06,0.
- rst_n pulsed low during COMPUTE cycle 2 -> all outputs return to reset values; a rerun of case 1 gives the correct result.
